counter_4bit: RTL and testbench
===============================

COUNTER_4BIT -- requirements
Module: counter_4bit

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; forces count to 0 immediately, independent of clk.
REQ-004 Qa  output  1  count bit 0 (LSB).
REQ-005 Qb  output  1  count bit 1.
REQ-006 Qc  output  1  count bit 2.
REQ-007 Qd  output  1  count bit 3 (MSB).
REQ-008 Rc  output  1  ripple carry; high while count = 15.
REQ-009 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-010 The block SHALL have no enable, load, or direction inputs; it counts freely whenever rst_n is high.

Function
REQ-011 The state SHALL be a 4-bit register Q = {Qd,Qc,Qb,Qa} that drives Qa..Qd directly, with no combinational logic on those outputs.
REQ-012 At each rising clk edge with rst_n high, Q SHALL become (Q + 1) mod 16.
REQ-013 The count SHALL wrap from 15 (1111) to 0 (0000) in one clock, with no stall and no extra state.
REQ-014 Rc SHALL be combinational: Rc = Qa & Qb & Qc & Qd.
- Rc is high for exactly one clock period out of every 16.
- Rc changes in the same cycle as the count.
REQ-015 Latency: a new count value SHALL be visible on Qa..Qd after the rising clk edge, with no additional pipeline delay.
REQ-016 Every output SHALL always have a defined value (no X or Z) once reset has been applied.
REQ-017 Toggle behaviour on each count:
- Qa SHALL toggle every clock.
- Qb SHALL toggle when Qa = 1.
- Qc SHALL toggle when Qa & Qb = 1.
- Qd SHALL toggle when Qa & Qb & Qc = 1.
- This is consistent with synchronous binary counting, so all bits update on the same edge.

Reset
REQ-018 While rst_n = 0:
- Q SHALL be 0000 and Rc SHALL be 0.
- These values SHALL be held regardless of clk activity.
REQ-019 Assertion of rst_n mid-count (including at count 15 with Rc high) SHALL clear Q and Rc without waiting for a clk edge.
REQ-020 After rst_n deasserts, the first rising clk edge with rst_n high SHALL produce count 1.
REQ-021 A clk edge coincident with rst_n deassertion SHALL leave Q at 0; counting resumes on the next edge.

Verification
REQ-022 Reset check: hold rst_n = 0 for 3 clocks (100 ns period) -> Qd..Qa = 0000 and Rc = 0 throughout.
REQ-023 Count sequence check: release rst_n, apply 15 edges -> Q reads 1, 2, ..., 15 in order; Rc = 1 only at Q = 15.
REQ-024 Wrap check: 16th edge after release -> Q = 0000 and Rc = 0; 32 edges in total -> Rc pulses exactly twice, at edges 15 and 31.
REQ-025 Asynchronous reset check: drop rst_n between clk edges while Q = 9 -> Q = 0000 before the next edge.
REQ-026 Mid-carry reset check: drop rst_n while Q = 15 and Rc = 1 -> Rc falls to 0 immediately.
REQ-027 Bit-period check: over 64 clocks after release -> Qa period = 2 clocks, Qb = 4, Qc = 8, Qd = 16, each with a 50% duty cycle.

Source files
------------

// File: rtl/counter_4bit.sv
// counter_4bit: free-running 4-bit synchronous binary counter
// with async active-low reset and combinational ripple carry.
module counter_4bit (
  input  logic clk,
  input  logic rst_n,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Rc
);

  logic [3:0] q;

  // count state: cleared at once by reset, else +1 mod 16 each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else        q <= q + 4'd1;
  end

  assign {Qd, Qc, Qb, Qa} = q;
  assign Rc = &q;

endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: vector table, corner sequences and random
// reset stimulus against an arithmetic count model.
module tb_counter_4bit;

  logic clk;
  logic rst_n;
  logic Qa, Qb, Qc, Qd, Rc;

  int n_checks;
  int n_fails;
  int model;

  typedef struct {
    int         edge_n;
    logic [3:0] q;
    logic       rc;
  } vec_t;

  vec_t tbl [32];

  counter_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Qa    (Qa),
    .Qb    (Qb),
    .Qc    (Qc),
    .Qd    (Qd),
    .Rc    (Rc)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] eq,
                     input logic erc);
    logic [3:0] aq;
    aq = {Qd, Qc, Qb, Qa};
    n_checks++;
    if (aq !== eq || Rc !== erc) begin
      n_fails++;
      $display("FAIL %s: got q=%b rc=%b, want q=%b rc=%b",
               nm, aq, Rc, eq, erc);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // assert reset between edges, hold 3 clocks, release mid-low
  task automatic do_reset();
    @(negedge clk);
    #10 rst_n = 1'b0;
    model = 0;
    #1 chk("reset_immediate", 4'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("reset_hold", 4'd0, 1'b0);
    end
    @(negedge clk);
    #10 rst_n = 1'b1;
  endtask

  // one edge with the model advanced from the count rule
  task automatic step(input string nm);
    @(posedge clk);
    if (rst_n) model = (model + 1) % 16;
    #1 chk(nm, 4'(model), model == 15);
  endtask

  initial begin
    int pulses, first_rc, second_rc;
    int tog [4];
    int high [4];
    logic [3:0] prev, cur;

    n_checks = 0;
    n_fails  = 0;
    model    = 0;
    rst_n    = 1'b0;

    for (int i = 0; i < 32; i++) begin
      tbl[i].edge_n = i + 1;
      tbl[i].q      = 4'((i + 1) % 16);
      tbl[i].rc     = ((i + 1) % 16) == 15;
    end

    // reset held from time 0 over several clocks
    repeat (3) begin
      @(posedge clk);
      #1 chk("reset_init", 4'd0, 1'b0);
    end

    do_reset();

    // 32 edges from release: sequence, wrap, two carry pulses
    pulses = 0;
    first_rc = -1;
    second_rc = -1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 chk($sformatf("seq_edge%0d", tbl[i].edge_n),
             tbl[i].q, tbl[i].rc);
      if (Rc === 1'b1) begin
        pulses++;
        if (first_rc < 0) first_rc = tbl[i].edge_n;
        else second_rc = tbl[i].edge_n;
      end
    end
    chk_int("rc_pulses", pulses, 2);
    chk_int("rc_first_edge", first_rc, 15);
    chk_int("rc_second_edge", second_rc, 31);

    // async reset between edges at count 9
    do_reset();
    repeat (9) step("to_nine");
    @(negedge clk);
    chk("at_nine", 4'd9, 1'b0);
    #10 rst_n = 1'b0;
    model = 0;
    #1 chk("async_rst_at9", 4'd0, 1'b0);
    @(negedge clk);
    chk("async_rst_at9_hold", 4'd0, 1'b0);
    #10 rst_n = 1'b1;
    step("first_after_rst");

    // async reset while carry is high at count 15
    repeat (14) step("to_fifteen");
    @(negedge clk);
    chk("at_fifteen", 4'd15, 1'b1);
    #5 rst_n = 1'b0;
    model = 0;
    #1 chk("carry_rst", 4'd0, 1'b0);
    @(negedge clk);
    #10 rst_n = 1'b1;

    // bit periods and duty over 64 edges after release
    do_reset();
    prev = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tog[k] = 0;
      high[k] = 0;
    end
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      #1 cur = {Qd, Qc, Qb, Qa};
      for (int k = 0; k < 4; k++) begin
        if (cur[k] !== prev[k]) tog[k]++;
        if (cur[k] === 1'b1) high[k]++;
      end
      prev = cur;
    end
    for (int k = 0; k < 4; k++) begin
      chk_int($sformatf("toggles_bit%0d", k), tog[k], 64 >> k);
      chk_int($sformatf("high_bit%0d", k), high[k], 32);
    end

    // random reset pulses against the count model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand_step");
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 30)) rst_n = 1'b0;
        model = 0;
        #1 chk("rand_rst", 4'd0, 1'b0);
        repeat ($urandom_range(0, 2)) step("rand_rst_hold");
        @(negedge clk);
        #($urandom_range(1, 30)) rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
